// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and default geometry.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_CHUNK = 4;

endpackage

// File: rtl/fulladder_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice used once per serial adder.
module fulladder_chunk
  import serial_adder_pkg::*;
#(
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[CHUNK];
  end

endmodule

// File: rtl/serial_adder_nb.sv
// Multi-cycle WIDTH-bit adder summing CHUNK bits per clock with a start/busy/done handshake.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b via ~b and carry-in of 1).
module serial_adder_nb
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

  if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_geometry
    $error("serial_adder_nb: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_t          state, state_nx;
  logic            accept;
  logic [IDXW-1:0] idx;
  logic            tail;
  logic [WIDTH-1:0] a_sh, b_sh, part;
  logic            carry_r;
  logic            a_msb, b_msb;
  logic [WIDTH-1:0] b_eff;
  logic            cin_eff;
  logic [CHUNK-1:0] chunk_sum;
  logic            chunk_cout;

  always_comb begin
    b_eff   = b;
    cin_eff = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_eff   = ~b;
      cin_eff = 1'b1;
    end
`endif
  end

  assign accept = start && (state != RUN);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = accept ? RUN : IDLE;
      RUN:     state_nx = tail ? DONE : RUN;
      DONE:    state_nx = accept ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  fulladder_chunk #(.CHUNK(CHUNK)) u_fa (
    .a    (a_sh[CHUNK-1:0]),
    .b    (b_sh[CHUNK-1:0]),
    .cin  (carry_r),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  // tail marks that the last chunk is stored; the following RUN cycle publishes
  // the result, giving the NCHUNK+1 edge latency from the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      part     <= '0;
      carry_r  <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      idx      <= '0;
      tail     <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_sh    <= a;
      b_sh    <= b_eff;
      part    <= '0;
      carry_r <= cin_eff;
      a_msb   <= a[WIDTH-1];
      b_msb   <= b_eff[WIDTH-1];
      idx     <= '0;
      tail    <= 1'b0;
    end else if (state == RUN) begin
      if (!tail) begin
        a_sh    <= a_sh >> CHUNK;
        b_sh    <= b_sh >> CHUNK;
        part    <= WIDTH'({chunk_sum, part} >> CHUNK);
        carry_r <= chunk_cout;
        if (idx == LAST) tail <= 1'b1;
        else             idx  <= idx + 1'b1;
      end else begin
        sum      <= part;
        carry    <= carry_r;
        overflow <= (a_msb == b_msb) && (part[WIDTH-1] != a_msb);
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_nb.sv
// Scoreboard bench for serial_adder_nb with CHUNK = 4 (directed) and CHUNK = 1/4/16 (random).
`timescale 1ns/1ps
module tb_serial_adder_nb;

  typedef struct {
    logic [17:0] res;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic cin = 1'b0, sub = 1'b0;
  logic start1 = 1'b0, start4 = 1'b0, start16 = 1'b0;
  logic busy1, busy4, busy16, done1, done4, done16;
  logic [15:0] sum1, sum4, sum16;
  logic carry1, carry4, carry16, ovf1, ovf4, ovf16;

  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  exp_t q1[$], q4[$], q16[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_nb #(.WIDTH(16), .CHUNK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy1), .done(done1), .sum(sum1), .carry(carry1), .overflow(ovf1));

  serial_adder_nb #(.WIDTH(16), .CHUNK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy4), .done(done4), .sum(sum4), .carry(carry4), .overflow(ovf4));

  serial_adder_nb #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy16), .done(done16), .sum(sum16), .carry(carry16), .overflow(ovf16));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: {overflow, carry, sum} of a + b_eff + c0.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic sb);
    logic [15:0] be;
    logic        c0;
    logic [16:0] r;
    be = sb ? ~y : y;
    c0 = sb ? 1'b1 : ci;
    r  = {1'b0, x} + {1'b0, be} + {16'd0, c0};
    return {(x[15] == be[15]) && (r[15] != x[15]), r};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done1) begin
      if (q1.size() == 0) check("c1_spurious_done", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        check("c1_result", {14'd0, ovf1, carry1, sum1}, {14'd0, e.res});
        check("c1_latency", cyc - e.cyc, 32'd17);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done4) begin
      if (q4.size() == 0) check("c4_spurious_done", 32'd1, 32'd0);
      else begin
        e = q4.pop_front();
        check("c4_result", {14'd0, ovf4, carry4, sum4}, {14'd0, e.res});
        check("c4_latency", cyc - e.cyc, 32'd5);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done16) begin
      if (q16.size() == 0) check("c16_spurious_done", 32'd1, 32'd0);
      else begin
        e = q16.pop_front();
        check("c16_result", {14'd0, ovf16, carry16, sum16}, {14'd0, e.res});
        check("c16_latency", cyc - e.cyc, 32'd2);
      end
    end
  end

  task automatic push4(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic sb);
    exp_t e;
    e.res = model(x, y, ci, sb);
    e.cyc = cyc;
    q4.push_back(e);
  endtask

  task automatic go4(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic sb);
    @(negedge clk);
    a = x; b = y; cin = ci; sub = sb; start4 = 1'b1;
    @(posedge clk); #1;
    push4(x, y, ci, sb);
    check("busy_in_run", {31'd0, busy4}, 32'd1);
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic wait4(input string tag);
    int unsigned n = 0;
    while (q4.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(tag, q4.size(), 32'd0);
  endtask

  task automatic check_res4(input string tag, input logic [15:0] s, input logic c, input logic o);
    check({tag, "_sum"}, {16'd0, sum4}, {16'd0, s});
    check({tag, "_carry"}, {31'd0, carry4}, {31'd0, c});
    check({tag, "_ovf"}, {31'd0, ovf4}, {31'd0, o});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n;
    logic [15:0] ra, rb;
    logic rc, rs;
    exp_t e;

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy4}, 32'd0);
    check("rst_done", {31'd0, done4}, 32'd0);
    check_res4("rst", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;

    go4(16'h00FF, 16'h0001, 1'b0, 1'b0);
    wait4("t1_timeout");
    check_res4("t1", 16'h0100, 1'b0, 1'b0);

    go4(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait4("t2a_timeout");
    check_res4("t2a", 16'h0000, 1'b1, 1'b0);
    go4(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait4("t2b_timeout");
    check_res4("t2b", 16'h8000, 1'b0, 1'b1);

    // Second start lands while busy and must be dropped.
    go4(16'h0001, 16'h0002, 1'b0, 1'b0);
    @(negedge clk);
    a = 16'h0009; b = 16'h0009; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    wait4("t3_timeout");
    repeat (8) @(negedge clk);
    check_res4("t3", 16'h0003, 1'b0, 1'b0);

    // Back-to-back: start raised while in DONE.
    go4(16'h0010, 16'h0020, 1'b1, 1'b0);
    n = 0;
    while (!done4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done_seen", {31'd0, done4}, 32'd1);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    push4(16'h1111, 16'h2222, 1'b0, 1'b0);
    check("b2b_busy", {31'd0, busy4}, 32'd1);
    @(negedge clk);
    start4 = 1'b0;
    wait4("b2b_timeout");
    check_res4("b2b", 16'h3333, 1'b0, 1'b0);

    // Reset two cycles into RUN aborts the operation.
    go4(16'h4000, 16'h4000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    q4.delete();
    check("abort_busy", {31'd0, busy4}, 32'd0);
    check("abort_done", {31'd0, done4}, 32'd0);
    check_res4("abort", 16'h0000, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    check("abort_no_done", {31'd0, done4}, 32'd0);
    rst_n = 1'b1;
    go4(16'h0123, 16'h0456, 1'b1, 1'b0);
    wait4("post_rst_timeout");
    check_res4("post_rst", 16'h057A, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    go4(16'h0005, 16'h0007, 1'b0, 1'b1);
    wait4("t5a_timeout");
    check_res4("t5a", 16'hFFFE, 1'b0, 1'b0);
    go4(16'h1234, 16'h1234, 1'b0, 1'b1);
    wait4("t5b_timeout");
    check_res4("t5b", 16'h0000, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      @(negedge clk);
      a = ra; b = rb; cin = rc; sub = rs;
      start1 = 1'b1; start4 = 1'b1; start16 = 1'b1;
      @(posedge clk); #1;
      e.res = model(ra, rb, rc, rs);
      e.cyc = cyc;
      q1.push_back(e);
      q4.push_back(e);
      q16.push_back(e);
      @(negedge clk);
      start1 = 1'b0; start4 = 1'b0; start16 = 1'b0;
      n = 0;
      while ((q1.size() + q4.size() + q16.size()) != 0 && n < 60) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
      check("rand_timeout", q1.size() + q4.size() + q16.size(), 32'd0);
      q1.delete(); q4.delete(); q16.delete();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
